// File: rtl/hcs_pkg.sv
// Shared types and helpers for the Han-Carlson pipelined subtractor.
// Stage mapping of the prefix levels lives here so the top and any reuse agree.
package hcs_pkg;

  localparam int HCS_LATENCY = 3;

  typedef struct packed {
    logic g;
    logic p;
  } hcs_gp_t;

  // Pipeline stage that computes prefix level k (level 1 = span 1).
  function automatic int hcs_level(input int k);
    if (k <= 1) begin
      return 1;
    end else if (k <= 4) begin
      return 2;
    end else begin
      return 3;
    end
  endfunction

endpackage

// File: rtl/hcs_prefix_node.sv
// Han-Carlson carry-operator cell: combines a high group with the adjacent low group.
module hcs_prefix_node
  import hcs_pkg::*;
(
  input  hcs_gp_t hi,
  input  hcs_gp_t lo,
  output hcs_gp_t o
);

  assign o.g = hi.g | (hi.p & lo.g);
  assign o.p = hi.p & lo.p;

endmodule

// File: rtl/hcs_sub_pipe.sv
// Three-stage valid/ready subtractor D = X - Y on a Han-Carlson prefix tree.
// Optional macro SUB_SAT_EN clamps diff to the signed range on overflow.
module hcs_sub_pipe
  import hcs_pkg::*;
#(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borrow,
  output logic         ovf
);

  localparam int NL      = $clog2(W);
  localparam int S2_LAST = (NL < 4) ? NL : 4;

  logic            v1_reg, v2_reg, v3_reg;
  logic            ld1, ld2, ld3;
  hcs_gp_t [W-1:0] gp0, s1_gp_reg, s2_gp_reg, fin;
  logic [W-1:0]    s1_p_reg, s2_p_reg;
  logic            s1_xs_reg, s1_ys_reg, s2_xs_reg, s2_ys_reg;
  logic [W-1:0]    full_g, carry, raw_diff, diff_next, unused_p;
  logic            borrow_next, ovf_next;

  // A stage loads when its successor is empty or draining this cycle.
  assign ld3       = !v3_reg || out_ready;
  assign ld2       = !v2_reg || ld3;
  assign ld1       = !v1_reg || ld2;
  assign in_ready  = ld1;
  assign out_valid = v3_reg;

  // Generate/propagate of X + ~Y with the +1 carry-in folded into bit 0.
  for (genvar gi = 0; gi < W; gi++) begin : gp_gen
    if (gi == 0) begin : cin_bit
      assign gp0[gi].g = (x[gi] & ~y[gi]) | (x[gi] ^ ~y[gi]);
    end else begin : plain_bit
      assign gp0[gi].g = x[gi] & ~y[gi];
    end
    assign gp0[gi].p = x[gi] ^ ~y[gi];
  end

  // Odd-bit Kogge-Stone levels; each level's source is a stage register at stage boundaries.
  for (genvar k = 1; k <= NL; k++) begin : lv
    localparam int SPAN = 1 << (k - 1);
    hcs_gp_t [W-1:0] src, res;

    if (k == 1) begin : from_gp
      assign src = gp0;
    end else if (hcs_level(k) != hcs_level(k - 1) && hcs_level(k) == 2) begin : from_s1
      assign src = s1_gp_reg;
    end else if (hcs_level(k) != hcs_level(k - 1)) begin : from_s2
      assign src = s2_gp_reg;
    end else begin : from_prev
      assign src = lv[k-1].res;
    end

    for (genvar gi = 0; gi < W; gi++) begin : node
      if ((gi % 2 == 1) && (gi >= SPAN)) begin : active
        hcs_prefix_node u_node (.hi(src[gi]), .lo(src[gi-SPAN]), .o(res[gi]));
      end else begin : pass
        assign res[gi] = src[gi];
      end
    end
  end

  if (NL > S2_LAST) begin : fin_stage3
    assign fin = lv[NL].res;
  end else begin : fin_stage2
    assign fin = s2_gp_reg;
  end

  // Even bits pick up the full prefix of the odd bit just below them.
  for (genvar gi = 0; gi < W; gi++) begin : fill
    if (gi == 0 || gi % 2 == 1) begin : direct
      assign full_g[gi]   = fin[gi].g;
      assign unused_p[gi] = fin[gi].p;
    end else begin : even
      hcs_gp_t fill_o;
      hcs_prefix_node u_fill (.hi(fin[gi]), .lo(fin[gi-1]), .o(fill_o));
      assign full_g[gi]   = fill_o.g;
      assign unused_p[gi] = fill_o.p;
    end
  end

  assign carry       = {full_g[W-2:0], 1'b1};
  assign raw_diff    = s2_p_reg ^ carry;
  assign borrow_next = ~full_g[W-1];
  assign ovf_next    = (s2_xs_reg != s2_ys_reg) && (raw_diff[W-1] != s2_xs_reg);

`ifdef SUB_SAT_EN
  assign diff_next = ovf_next ? {s2_xs_reg, {(W-1){~s2_xs_reg}}} : raw_diff;
`else
  assign diff_next = raw_diff;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg    <= 1'b0;
      s1_gp_reg <= '0;
      s1_p_reg  <= '0;
      s1_xs_reg <= 1'b0;
      s1_ys_reg <= 1'b0;
    end else if (ld1) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        s1_gp_reg <= lv[1].res;
        s1_p_reg  <= x ^ ~y;
        s1_xs_reg <= x[W-1];
        s1_ys_reg <= y[W-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg    <= 1'b0;
      s2_gp_reg <= '0;
      s2_p_reg  <= '0;
      s2_xs_reg <= 1'b0;
      s2_ys_reg <= 1'b0;
    end else if (ld2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        s2_gp_reg <= lv[S2_LAST].res;
        s2_p_reg  <= s1_p_reg;
        s2_xs_reg <= s1_xs_reg;
        s2_ys_reg <= s1_ys_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_reg <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else if (ld3) begin
      v3_reg <= v2_reg;
      if (v2_reg) begin
        diff   <= diff_next;
        borrow <= borrow_next;
        ovf    <= ovf_next;
      end
    end
  end

endmodule
